memory_stage: RTL

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// memory_stage: EX/MEM register, byte-lane data-memory access with wait states, MEM/WB register.
// Define MEM_MISALIGN_TRAP_EN to suppress and flag misaligned halfword/word accesses.
module memory_stage #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_e,
   input  logic                  reg_write_e,
   input  logic [1:0]            res_src_e,
   input  logic                  mem_write_e,
   input  logic [2:0]            funct3_e,
   input  logic [DATA_WIDTH-1:0] alu_result_e,
   input  logic [DATA_WIDTH-1:0] write_data_e,
   input  logic [4:0]            rd_e,
   input  logic [DATA_WIDTH-1:0] pc_plus4_e,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [3:0]            dmem_be,
   output logic [DATA_WIDTH-1:0] dmem_addr,
   output logic [DATA_WIDTH-1:0] dmem_wdata,
   input  logic [DATA_WIDTH-1:0] dmem_rdata,
   input  logic                  dmem_ready,
   output logic                  valid_w,
   output logic                  reg_write_w,
   output logic [4:0]            rd_w,
   output logic [DATA_WIDTH-1:0] result_w,
   output logic                  stall_m,
   output logic                  misaligned_m
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   typedef struct packed {
      logic                  valid;
      logic                  reg_write;
      logic [1:0]            res_src;
      logic                  mem_write;
      logic [2:0]            funct3;
      logic [DATA_WIDTH-1:0] alu_result;
      logic [DATA_WIDTH-1:0] write_data;
      logic [4:0]            rd;
      logic [DATA_WIDTH-1:0] pc_plus4;
   } ex_mem_t;

   ex_mem_t               m;
   state_t                state;
   logic                  is_mem;
   logic                  misaligned;
   logic [1:0]            lane;
   logic [7:0]            ld_byte;
   logic [15:0]           ld_half;
   logic [DATA_WIDTH-1:0] load_data;
   logic [DATA_WIDTH-1:0] result_m;

   assign lane   = m.alu_result[1:0];
   assign is_mem = m.valid & ((m.res_src == 2'b01) | m.mem_write);

`ifdef MEM_MISALIGN_TRAP_EN
   assign misaligned   = ((m.funct3[1:0] == 2'b01) & lane[0]) |
                         ((m.funct3[1:0] == 2'b10) & (lane != 2'b00));
   assign misaligned_m = is_mem & misaligned;
`else
   assign misaligned   = 1'b0;
   assign misaligned_m = 1'b0;
`endif

   assign dmem_req  = is_mem & ~misaligned;
   assign dmem_we   = m.mem_write;
   assign dmem_addr = {m.alu_result[DATA_WIDTH-1:2], 2'b00};
   assign stall_m   = dmem_req & ~dmem_ready;

   // NOTE: every output of a combinational block gets a default first so no path infers a latch.
   always_comb begin
      dmem_be    = 4'b1111;
      dmem_wdata = m.write_data;
      if (m.mem_write) begin
         case (m.funct3[1:0])
            2'b00: begin
               dmem_be    = 4'b0001 << lane;
               dmem_wdata = {4{m.write_data[7:0]}};
            end
            2'b01: begin
               dmem_be    = lane[1] ? 4'b1100 : 4'b0011;
               dmem_wdata = {2{m.write_data[15:0]}};
            end
            default: ;
         endcase
      end
   end

   // Sign extension is disabled by funct3[2] (BU/HU).
   always_comb begin
      ld_byte = dmem_rdata[{lane, 3'b000} +: 8];
      ld_half = lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (m.funct3[1:0])
         2'b00:   load_data = {{(DATA_WIDTH-8){~m.funct3[2] & ld_byte[7]}}, ld_byte};
         2'b01:   load_data = {{(DATA_WIDTH-16){~m.funct3[2] & ld_half[15]}}, ld_half};
         default: load_data = dmem_rdata;
      endcase
      case (m.res_src)
         2'b01:   result_m = load_data;
         2'b10:   result_m = m.pc_plus4;
         default: result_m = m.alu_result;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         m           <= '0;
         valid_w     <= 1'b0;
         reg_write_w <= 1'b0;
         rd_w        <= '0;
         result_w    <= '0;
      end else begin
         case (state)
            S_IDLE: if (stall_m)    state <= S_WAIT;
            S_WAIT: if (dmem_ready) state <= S_IDLE;
         endcase
         if (!stall_m) begin
            m <= '{valid: valid_e, reg_write: reg_write_e, res_src: res_src_e,
                   mem_write: mem_write_e, funct3: funct3_e, alu_result: alu_result_e,
                   write_data: write_data_e, rd: rd_e, pc_plus4: pc_plus4_e};
            valid_w     <= m.valid;
            reg_write_w <= m.valid & m.reg_write & ~misaligned;
            rd_w        <= m.rd;
            result_w    <= result_m;
         end else begin
            valid_w     <= 1'b0;
            reg_write_w <= 1'b0;
         end
      end
   end

   // A pending transfer keeps its request raised until dmem_ready completes it.
   always @(posedge clk) begin
      if (!rst && state == S_WAIT) assert (dmem_req);
   end

endmodule
